io_input_port: RTL and testbench
================================

// Module: io_input_port
// PURPOSE
//  Upstream feeder for the memory-mapped Input word of the data Memory block.
//  - Synchronises and debounces the board "submit" button and samples the 16-bit switch bank.
//  - Holds one captured word with a valid flag until the CPU-side read acknowledges it.
//  - Flags lost presses.
//  - Drives Memory's Input bus; InputAck comes from Memory's input-read decode.
// PARAMETERS
//  WIDTH            16  data width of Switches/Input
//  SYNC_STAGES      2   flops in each synchroniser chain (>=2)
//  DEBOUNCE_CYCLES  16  consecutive stable cycles required to accept a button edge (>=2)
// PORTS
//  Clk        in   1      system clock, all state on rising edge
//  Rst_n      in   1      asynchronous, active-low reset
//  Switches   in   WIDTH  raw asynchronous switch bank
//  Button     in   1      raw asynchronous submit button, active-high
//  InputAck   in   1      1-cycle pulse: CPU has read Input, release the word
//  OverrunClr in   1      clears Overrun
//  Input      out  WIDTH  held captured word (to Memory Input)
//  InputValid out  1      Input holds an unread word
//  Overrun    out  1      sticky: a press was dropped because a word was unread
//  BtnLevel   out  1      debounced button level (status/LED)
// BEHAVIOUR
//  Interface
//  - One clock domain (Clk).
//  - Reset is asynchronous, active-low (Rst_n).
//  Reset state
//  - Rst_n=0 forces: all sync flops=0, FSM=LOW, counter=0.
//  - Outputs on reset: Input=0, InputValid=0, Overrun=0, BtnLevel=0.
//  Synchronisers
//  - Button and every Switches bit pass through SYNC_STAGES flops; call the results btn_s and sw_s.
//  Debounce FSM (states LOW, RISE_CHK, HIGH, FALL_CHK; cnt is a counter wide enough for DEBOUNCE_CYCLES-1)
//  - LOW: btn_s=1 -> RISE_CHK, cnt=1.
//  - RISE_CHK:
//    - btn_s=0 -> LOW, cnt=0.
//    - btn_s=1 and cnt==DEBOUNCE_CYCLES-1 -> HIGH, cnt=0, press=1 for that cycle.
//    - otherwise cnt+1.
//  - HIGH: btn_s=0 -> FALL_CHK, cnt=1.
//  - FALL_CHK:
//    - btn_s=1 -> HIGH, cnt=0.
//    - btn_s=0 and cnt==DEBOUNCE_CYCLES-1 -> LOW, cnt=0.
//    - otherwise cnt+1.
//  - BtnLevel=1 in HIGH and FALL_CHK, else 0.
//  - A button held for any length produces exactly one press.
//  Latency
//  - Button rises and stays high.
//  - press is asserted in the cycle after edge SYNC_STAGES+DEBOUNCE_CYCLES, counting the first edge that samples Button=1 as edge 1.
//  - InputValid rises on the next edge.
//  Holding register (evaluated on each edge)
//  - press & !InputValid: Input<=sw_s, InputValid<=1.
//  - press & InputValid & InputAck: Input<=sw_s, InputValid stays 1 (ack of old word, capture of new word).
//  - press & InputValid & !InputAck: Input unchanged, Overrun<=1.
//  - !press & InputAck: InputValid<=0, Input unchanged.
//  - InputAck with InputValid=0 is ignored.
//  Overrun
//  - OverrunClr clears Overrun.
//  - If OverrunClr and an overrun event occur in the same cycle, set wins (Overrun=1).
//  - Input changes only on capture; it is never cleared except by reset.
//  Reset mid-operation
//  - Rst_n low for any part of a debounce or held word discards it; no press is emitted after release.
//  - After Rst_n deasserts with Button already high, a full debounce is required before the press is accepted.
// TESTING (bench uses SYNC_STAGES=2, DEBOUNCE_CYCLES=4, Clk period 20ns)
//  1. Reset: Rst_n=0 mid-cycle with Switches=16'hFFFF, Button=1 -> all outputs 0 immediately (async).
//  2. Clean press: Switches=16'h1234, Button high 20 cycles -> InputValid=1 and Input=16'h1234 at edge 7 after first sample; single capture.
//  3. Bounce: Button high 2 cycles, low 1, high 10 -> no capture during the bounce; exactly one capture, timed from the last rise.
//  4. Ack: with InputValid=1, pulse InputAck 1 cycle -> InputValid=0 next edge, Input still 16'h1234.
//  5. Overrun: hold 16'hAAAA unread, second full press with Switches=16'h5555 -> Input=16'hAAAA, Overrun=1; OverrunClr -> Overrun=0.
//  6. Same-cycle press+ack: time InputAck onto the press cycle, Switches=16'hBEEF -> Input=16'hBEEF, InputValid stays 1, Overrun=0.

Source files
------------

// File: rtl/io_input_port.sv
// io_input_port: synchronises and debounces the submit button, samples the
// switch bank, and holds one captured word for the CPU until it is acknowledged.
// Lost presses (a press while a word is still unread) set a sticky Overrun flag.
module io_input_port #(
  parameter int WIDTH           = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [WIDTH-1:0] Switches,
  input  logic             Button,
  input  logic             InputAck,
  input  logic             OverrunClr,
  output logic [WIDTH-1:0] Input,
  output logic             InputValid,
  output logic             Overrun,
  output logic             BtnLevel
);

  // Counter only ever needs to reach DEBOUNCE_CYCLES-1.
  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_LOW,
    S_RISE_CHK,
    S_HIGH,
    S_FALL_CHK
  } state_t;

  logic [SYNC_STAGES-1:0]            btn_sync;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sw_sync;
  logic                              btn_s;
  logic [WIDTH-1:0]                  sw_s;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          press, press_nxt;
  logic          overrun_set;

  assign btn_s = btn_sync[SYNC_STAGES-1];
  assign sw_s  = sw_sync[SYNC_STAGES-1];

  // Synchroniser chains for the button and every switch bit.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      btn_sync <= '0;
      sw_sync  <= '0;
    end else begin
      btn_sync <= {btn_sync[SYNC_STAGES-2:0], Button};
      sw_sync  <= {sw_sync[SYNC_STAGES-2:0], Switches};
    end
  end

  // Debounce state, stability counter and the one-cycle press strobe.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= S_LOW;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      press <= press_nxt;
    end
  end

  // Debounce next-state: an edge is accepted only after the synchronised level
  // has been stable for DEBOUNCE_CYCLES consecutive cycles.
  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    press_nxt = 1'b0;
    unique case (state)
      S_LOW: begin
        if (btn_s) begin
          state_nxt = S_RISE_CHK;
          cnt_nxt   = CW'(1);
        end
      end
      S_RISE_CHK: begin
        if (!btn_s) begin
          state_nxt = S_LOW;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = S_HIGH;
          cnt_nxt   = '0;
          press_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_HIGH: begin
        if (!btn_s) begin
          state_nxt = S_FALL_CHK;
          cnt_nxt   = CW'(1);
        end
      end
      S_FALL_CHK: begin
        if (btn_s) begin
          state_nxt = S_HIGH;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = S_LOW;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = S_LOW;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign BtnLevel    = (state == S_HIGH) || (state == S_FALL_CHK);
  assign overrun_set = press && InputValid && !InputAck;

  // Holding register: capture on press when the slot is free or being
  // released this cycle; otherwise the press is dropped and flagged.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Input      <= '0;
      InputValid <= 1'b0;
    end else if (press) begin
      if (!InputValid || InputAck) begin
        Input      <= sw_s;
        InputValid <= 1'b1;
      end
    end else if (InputAck) begin
      InputValid <= 1'b0;
    end
  end

  // Sticky overrun flag; a new overrun beats a simultaneous clear.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Overrun <= 1'b0;
    end else if (overrun_set) begin
      Overrun <= 1'b1;
    end else if (OverrunClr) begin
      Overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_io_input_port.sv
// tb_io_input_port: directed checks of reset, debounce latency, bounce
// rejection, acknowledge, overrun and same-cycle press/ack behaviour.
module tb_io_input_port;

  logic        Clk;
  logic        Rst_n;
  logic [15:0] Switches;
  logic        Button;
  logic        InputAck;
  logic        OverrunClr;
  logic [15:0] Input;
  logic        InputValid;
  logic        Overrun;
  logic        BtnLevel;

  int checks = 0;
  int errors = 0;

  io_input_port #(
    .WIDTH          (16),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .Switches  (Switches),
    .Button    (Button),
    .InputAck  (InputAck),
    .OverrunClr(OverrunClr),
    .Input     (Input),
    .InputValid(InputValid),
    .Overrun   (Overrun),
    .BtnLevel  (BtnLevel)
  );

  initial Clk = 1'b0;
  always #10 Clk = ~Clk;

  // Advance n rising edges, leaving time 1ns after the last edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Full press and release, long enough for both debounce directions.
  task automatic full_press(input logic [15:0] sw);
    Switches = sw;
    Button   = 1'b1;
    tick(8);
    Button = 1'b0;
    tick(12);
  endtask

  initial begin
    Rst_n      = 1'b1;
    Switches   = 16'hFFFF;
    Button     = 1'b1;
    InputAck   = 1'b0;
    OverrunClr = 1'b0;
    tick(2);

    // 1. Asynchronous reset mid-cycle.
    #5 Rst_n = 1'b0;
    #1;
    check("rst_input",   Input,             16'h0000);
    check("rst_valid",   16'(InputValid),   16'h0);
    check("rst_overrun", 16'(Overrun),      16'h0);
    check("rst_btnlvl",  16'(BtnLevel),     16'h0);
    Button = 1'b0;
    tick(3);
    check("rst_hold_valid", 16'(InputValid), 16'h0);
    Rst_n = 1'b1;
    tick(4);
    check("idle_valid", 16'(InputValid), 16'h0);

    // 2. Clean press: valid rises on edge 7 after the first sample.
    Switches = 16'h1234;
    Button   = 1'b1;
    tick(5);
    check("clean_btnlvl_e5", 16'(BtnLevel),   16'h0);
    tick(1);
    check("clean_valid_e6",  16'(InputValid), 16'h0);
    check("clean_btnlvl_e6", 16'(BtnLevel),   16'h1);
    tick(1);
    check("clean_valid_e7",  16'(InputValid), 16'h1);
    check("clean_input_e7",  Input,           16'h1234);
    tick(13);
    check("clean_single",    16'(Overrun),    16'h0);
    Button = 1'b0;
    tick(12);
    check("clean_release_lvl", 16'(BtnLevel),   16'h0);
    check("clean_still_valid", 16'(InputValid), 16'h1);

    // 4. Acknowledge releases the word; Input is retained.
    InputAck = 1'b1;
    tick(1);
    InputAck = 1'b0;
    check("ack_valid", 16'(InputValid), 16'h0);
    check("ack_input", Input,           16'h1234);
    InputAck = 1'b1;
    tick(1);
    InputAck = 1'b0;
    check("ack_idle_valid", 16'(InputValid), 16'h0);
    check("ack_idle_input", Input,           16'h1234);

    // 3. Bounce: high 2, low 1, high 10; timed from the last rise.
    Switches = 16'h0F0F;
    Button   = 1'b1;
    tick(2);
    Button = 1'b0;
    tick(1);
    Button = 1'b1;
    tick(5);
    check("bounce_valid_e8", 16'(InputValid), 16'h0);
    tick(1);
    check("bounce_valid_e9", 16'(InputValid), 16'h0);
    tick(1);
    check("bounce_valid_e10", 16'(InputValid), 16'h1);
    check("bounce_input",     Input,           16'h0F0F);
    tick(3);
    Button = 1'b0;
    tick(12);
    check("bounce_single", 16'(Overrun), 16'h0);
    InputAck = 1'b1;
    tick(1);
    InputAck = 1'b0;
    check("bounce_ack_valid", 16'(InputValid), 16'h0);

    // 5. Overrun: unread word, second press is dropped.
    full_press(16'hAAAA);
    check("ovr_first_input",   Input,           16'hAAAA);
    check("ovr_first_overrun", 16'(Overrun),    16'h0);
    full_press(16'h5555);
    check("ovr_input",   Input,           16'hAAAA);
    check("ovr_valid",   16'(InputValid), 16'h1);
    check("ovr_overrun", 16'(Overrun),    16'h1);
    OverrunClr = 1'b1;
    tick(1);
    OverrunClr = 1'b0;
    check("ovr_clr", 16'(Overrun), 16'h0);

    // 6. Ack lands in the press cycle: old word released, new word captured.
    Switches = 16'hBEEF;
    Button   = 1'b1;
    tick(6);
    check("same_before_input", Input, 16'hAAAA);
    InputAck = 1'b1;
    tick(1);
    InputAck = 1'b0;
    check("same_input",   Input,           16'hBEEF);
    check("same_valid",   16'(InputValid), 16'h1);
    check("same_overrun", 16'(Overrun),    16'h0);
    Button = 1'b0;
    tick(12);

    // Overrun set beats a clear in the same cycle.
    Switches = 16'h1111;
    Button   = 1'b1;
    tick(6);
    OverrunClr = 1'b1;
    tick(1);
    OverrunClr = 1'b0;
    check("setwin_overrun", 16'(Overrun), 16'h1);
    check("setwin_input",   Input,        16'hBEEF);
    Button = 1'b0;
    tick(12);

    // Reset during a debounce discards it; a full debounce follows release.
    Switches = 16'hCAFE;
    Button   = 1'b1;
    tick(4);
    Rst_n = 1'b0;
    #1;
    check("midrst_input",   Input,          16'h0000);
    check("midrst_valid",   16'(InputValid), 16'h0);
    check("midrst_overrun", 16'(Overrun),    16'h0);
    tick(2);
    Rst_n = 1'b1;
    tick(6);
    check("midrst_valid_e6", 16'(InputValid), 16'h0);
    tick(1);
    check("midrst_valid_e7", 16'(InputValid), 16'h1);
    check("midrst_input_e7", Input,           16'hCAFE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
